seq_sub16: RTL and testbench

SEQ_SUB16 -- requirements
Module: seq_sub16

---
 rtl/seq_sub16.sv | 147 ++++++++++++++
 tb/tb_seq_sub16.sv | 123 ++++++++++++
 2 files changed

// File: rtl/seq_sub16.sv
// Sequential WIDTH-bit subtractor. It processes one 4-bit borrow-lookahead slice per cycle, from LSB to MSB.
// Optional zero/ovf flags are built when SEQ_SUB16_FLAGS_EN is defined; otherwise both ports are tied to 0.
module seq_sub16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned S    = WIDTH / 4;
    localparam int unsigned CW   = (S > 1) ? $clog2(S) : 1;
    localparam logic [CW-1:0] LAST = CW'(S - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_r, b_r;
    logic             bin_r;
    logic [CW-1:0]    cnt;
    logic             borrow_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;

    logic [3:0]       sa, sb, g, p, sd;
    logic [4:0]       c;
    logic             sbin;
    logic [WIDTH-1:0] diff_n;

    // Select the active slice and resolve its internal borrows in parallel.
    always_comb begin
        sa = '0;
        sb = '0;
        for (int unsigned k = 0; k < S; k++) begin
            if (cnt == CW'(k)) begin
                sa = a_r[4*k +: 4];
                sb = b_r[4*k +: 4];
            end
        end
        sbin = (cnt == '0) ? bin_r : borrow_r;
        g    = ~sa & sb;
        p    = ~(sa ^ sb);
        c[0] = sbin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sd   = sa ^ sb ^ c[3:0];
        diff_n = diff_r;
        for (int unsigned k = 0; k < S; k++) begin
            if (cnt == CW'(k)) begin
                diff_n[4*k +: 4] = sd;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = RUN;
            RUN:     if (cnt == LAST) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            bin_r    <= 1'b0;
            cnt      <= '0;
            borrow_r <= 1'b0;
            diff_r   <= '0;
            bout_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        bin_r <= bin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    diff_r   <= diff_n;
                    borrow_r <= c[4];
                    // Hold the counter on the last slice so it never wraps into a further slice.
                    if (cnt == LAST) begin
                        bout_r <= c[4];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = diff_r;
    assign bout      = bout_r;

`ifdef SEQ_SUB16_FLAGS_EN
    logic zero_r, ovf_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (state == RUN && cnt == LAST) begin
            zero_r <= (diff_n == '0);
            ovf_r  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_n[WIDTH-1] != a_r[WIDTH-1]);
        end
    end

    assign zero = zero_r;
    assign ovf  = ovf_r;
`else
    assign zero = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_sub16.sv
// Directed self-checking bench for seq_sub16 (WIDTH=16).
// It expects zero/ovf values that match the build's SEQ_SUB16_FLAGS_EN setting.
module tb_seq_sub16;

`ifdef SEQ_SUB16_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, bin, out_valid, out_ready, bout, zero, ovf;
    logic [15:0] a, b, diff;

    int n_assert = 0;
    int n_fail   = 0;

    seq_sub16 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_diff"}, 32'(diff), 32'h0);
        check({tag, "_bout"}, 32'(bout), 32'h0);
        check({tag, "_zero"}, 32'(zero), 32'h0);
        check({tag, "_ovf"},  32'(ovf),  32'h0);
        check({tag, "_ovalid"}, 32'(out_valid), 32'h0);
        check({tag, "_iready"}, 32'(in_ready), 32'h1);
    endtask

    // Accept one operand set, scramble the inputs after capture, measure latency, check the result, and release it.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tbin, input logic [15:0] ediff, input logic ebout,
                          input logic ezero, input logic eovf, input bit hold);
        int lat;
        @(negedge clk);
        check({tag, "_iready_pre"}, 32'(in_ready), 32'h1);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        check({tag, "_iready_run"}, 32'(in_ready), 32'h0);
        in_valid = 1'b0; a = ~ta; b = ta ^ 16'h5a5a; bin = ~tbin;
        lat = 0;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_diff"}, 32'(diff), 32'(ediff));
        check({tag, "_bout"}, 32'(bout), 32'(ebout));
        check({tag, "_zero"}, 32'(zero), 32'(ezero & FLAGS));
        check({tag, "_ovf"},  32'(ovf),  32'(eovf & FLAGS));
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                in_valid = 1'b1; a = 16'(i * 16'h1111); b = 16'h0f0f; bin = 1'b1;
                @(posedge clk); #1;
                check({tag, "_hold_ovalid"}, 32'(out_valid), 32'h1);
                check({tag, "_hold_iready"}, 32'(in_ready), 32'h0);
                check({tag, "_hold_diff"}, 32'(diff), 32'(ediff));
                check({tag, "_hold_bout"}, 32'(bout), 32'(ebout));
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_release_ovalid"}, 32'(out_valid), 32'h0);
        check({tag, "_release_iready"}, 32'(in_ready), 32'h1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sub_5_3",     16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sub_3_5",     16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("ripple_bin",  16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("ovf_8000",    16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("zero_1234",   16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("ffff_bin",    16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("ovf_neg",     16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("slice_cross", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("backpress",   16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b1);

        // Assert reset during the second RUN cycle; the in-flight result must vanish.
        @(negedge clk);
        a = 16'hAAAA; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post_reset_no_ovalid", 32'(out_valid), 32'h0);
        end
        run_op("after_reset", 16'h0009, 16'h0004, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
